// File: rtl/bus_drvr_port_if.sv
// Arbiter-facing bus of one driver port.
// The arbiter (master) drains the TX FIFO through pndng/pop/D_pop
// and fills the RX FIFO through push/D_push.
interface bus_drvr_port_if #(
  parameter int PCKG = 32
);
  logic            pndng;
  logic            pop;
  logic [PCKG-1:0] D_pop;
  logic            push;
  logic [PCKG-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_drvr_port.sv
// Device-side endpoint of the bus: a TX FIFO drained by the arbiter and an
// RX FIFO filled by the arbiter, with packets filtered on destination ID.
// Both FIFOs are first-word fall-through; heads read as 0 when empty.
module bus_drvr_port #(
  parameter int PCKG    = 32,
  parameter int DEPTH   = 8,
  parameter int ID_W    = 8,
  parameter int DRVR_ID = 0,
  parameter int BROD    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [PCKG-1:0]        wr_data,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_count,
  bus_drvr_port_if.slave         bus,
  input  logic                   rd_en,
  output logic [PCKG-1:0]        rd_data,
  output logic                   rx_empty,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   ovf,
  output logic [15:0]            drop_cnt,
  output logic                   pop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [ID_W-1:0] OWN_ID   = ID_W'(DRVR_ID);
  localparam logic [ID_W-1:0] BROD_ID  = ID_W'(BROD);

  logic [PCKG-1:0] tx_mem [DEPTH];
  logic [PCKG-1:0] rx_mem [DEPTH];
  logic [AW-1:0]   tx_rd_ptr, tx_wr_ptr;
  logic [AW-1:0]   rx_rd_ptr, rx_wr_ptr;

  logic tx_empty_i, tx_full_i, rx_empty_i, rx_full_i;
  logic tx_do_rd, tx_do_wr, rx_do_rd, rx_do_wr;
  logic id_match, rx_drop;

  assign tx_empty_i = (tx_count == '0);
  assign tx_full_i  = (tx_count == FULL_CNT);
  assign rx_empty_i = (rx_count == '0);
  assign rx_full_i  = (rx_count == FULL_CNT);

  // A pop on a full FIFO frees a slot in the same cycle, so a simultaneous
  // write is allowed; the same holds for a host read on a full RX FIFO.
  assign tx_do_rd = bus.pop & ~tx_empty_i;
  assign tx_do_wr = wr_en & (~tx_full_i | tx_do_rd);

  assign id_match = (bus.D_push[PCKG-1 -: ID_W] == OWN_ID) ||
                    (bus.D_push[PCKG-1 -: ID_W] == BROD_ID);
  assign rx_do_rd = rd_en & ~rx_empty_i;
  assign rx_do_wr = bus.push & id_match & (~rx_full_i | rx_do_rd);
  assign rx_drop  = bus.push & id_match & rx_full_i & ~rx_do_rd;

  assign tx_full   = tx_full_i;
  assign bus.pndng = ~tx_empty_i;
  assign bus.D_pop = tx_empty_i ? '0 : tx_mem[tx_rd_ptr];
  assign rx_empty  = rx_empty_i;
  assign rd_data   = rx_empty_i ? '0 : rx_mem[rx_rd_ptr];

  // TX storage; stale entries are never visible because the head is masked when empty
  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wr_ptr] <= wr_data;
  end

  // RX storage, written only for accepted packets that have room
  always_ff @(posedge clk) begin
    if (rx_do_wr) rx_mem[rx_wr_ptr] <= bus.D_push;
  end

  // TX pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_do_wr) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_do_rd) tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_count <= tx_count + CW'(tx_do_wr) - CW'(tx_do_rd);
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_do_wr) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_do_rd) rx_rd_ptr <= rx_rd_ptr + AW'(1);
      rx_count <= rx_count + CW'(rx_do_wr) - CW'(rx_do_rd);
    end
  end

  // Sticky error flags and the saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
      pop_err  <= 1'b0;
    end else begin
      if (bus.pop && tx_empty_i) pop_err <= 1'b1;
      if (rx_drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
